// File: rtl/bl_fifo_pkg.sv
// Shared sizing constants and level-compare helpers for the FIFO controller.
//   fifo_depth(aw) : number of words for a given address width
//   ptr_width(aw)  : pointer width, one extra MSB to tell full from empty
//   level_ge/le    : threshold compares used by the almost_full/almost_empty flags
package bl_fifo_pkg;

  localparam int unsigned PTR_EXTRA_BITS = 1;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + PTR_EXTRA_BITS;
  endfunction

  function automatic logic level_ge(input int unsigned lvl, input int unsigned thr);
    return lvl >= thr;
  endfunction

  function automatic logic level_le(input int unsigned lvl, input int unsigned thr);
    return lvl <= thr;
  endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM with registered read.
//   wr_clk, wr_en, wr_addr, wr_data : write port
//   rd_clk, rd_addr, rd_data        : read port, rd_data valid one rd_clk edge after rd_addr
// Contents are not initialised or cleared.
module dpram
  import bl_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  wr_clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_clk,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [fifo_depth(ADDR_WIDTH)];

  always_ff @(posedge wr_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge rd_clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock first-word-fall-through FIFO controller around one dpram.
//   clk, rst (sync, active-high)
//   wr_valid/wr_ready/wr_data : producer side, wr_ready = !full
//   rd_valid/rd_ready/rd_data : consumer side, rd_data straight from dpram
//   level, full, empty        : occupancy
//   almost_full, almost_empty : only when SYNC_FIFO_ALMOST_EN is defined,
//                               registered from the next level
module sync_fifo_ctrl
  import bl_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 4,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_ALMOST_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam int unsigned PW      = ptr_width(ADDR_WIDTH);
  localparam int unsigned DEPTH   = fifo_depth(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0]         wr_ptr, pop_ptr, fetch_ptr;
  logic [PW-1:0]         wr_ptr_nxt, pop_ptr_nxt;
  logic                  rd_valid_nxt;
  logic                  push, pop, fetch;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign level    = wr_ptr - pop_ptr;
  assign full     = (level == DEPTH_P);
  assign empty    = (level == '0);
  assign wr_ready = ~full;

  // The word on rd_data (when rd_valid) still occupies slot pop_ptr, so the
  // next word to fetch sits one beyond it. While stalled, the head address is
  // re-read so rd_data stays stable.
  always_comb begin
    push         = wr_valid & wr_ready;
    pop          = rd_valid & rd_ready;
    fetch_ptr    = pop_ptr + PW'(rd_valid);
    fetch        = (fetch_ptr != wr_ptr) & (~rd_valid | pop);
    rd_addr      = fetch ? fetch_ptr[ADDR_WIDTH-1:0] : pop_ptr[ADDR_WIDTH-1:0];
    wr_ptr_nxt   = push ? wr_ptr + PW'(1) : wr_ptr;
    pop_ptr_nxt  = pop ? pop_ptr + PW'(1) : pop_ptr;
    rd_valid_nxt = fetch ? 1'b1 : (pop ? 1'b0 : rd_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      pop_ptr  <= '0;
      rd_valid <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      pop_ptr  <= pop_ptr_nxt;
      rd_valid <= rd_valid_nxt;
    end
  end

`ifdef SYNC_FIFO_ALMOST_EN
  logic [PW-1:0] level_nxt;

  // Registered from the next level so the flags change on the same edge as level.
  assign level_nxt = rst ? '0 : (wr_ptr_nxt - pop_ptr_nxt);

  always_ff @(posedge clk) begin
    almost_full  <= level_ge(32'(level_nxt), AF_LEVEL);
    almost_empty <= level_le(32'(level_nxt), AE_LEVEL);
  end
`endif

  dpram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dpram (
    .wr_clk  (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_clk  (clk),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl (ADDR_WIDTH=3, DATA_WIDTH=8).
// Reference model: a queue of (data, push cycle). The head is visible on
// rd_valid once it has been in the FIFO for two cycles; level is queue size.
module tb_sync_fifo_ctrl;

  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst, wr_valid, wr_ready, rd_valid, rd_ready, full, empty;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW:0]   level;
`ifdef SYNC_FIFO_ALMOST_EN
  logic          almost_full, almost_empty;
`endif

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .level    (level),
    .full     (full),
    .empty    (empty)
`ifdef SYNC_FIFO_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  typedef struct {
    logic [DW-1:0] d;
    int unsigned   t;
  } ent_t;

  ent_t          q[$];
  int unsigned   cyc = 0;
  int            total = 0;
  int            bad = 0;

  int unsigned   exp_level;
  bit            exp_full, exp_valid;
  logic [DW-1:0] exp_data;
  bit            in_wv, in_rr, in_rs;
  logic [DW-1:0] in_wd;

  // Apply inputs for the current cycle and derive expected outputs from the model.
  task automatic drive(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit rs);
    wr_valid = wv; wr_data = wd; rd_ready = rr; rst = rs;
    in_wv = wv; in_wd = wd; in_rr = rr; in_rs = rs;
    #1;
    exp_level = q.size();
    exp_full  = (exp_level == DEPTH);
    exp_valid = (q.size() > 0) && (q[0].t + 2 <= cyc);
    exp_data  = exp_valid ? q[0].d : '0;
  endtask

  // Commit the cycle's transfers to the model and move past the clock edge.
  task automatic advance();
    bit pop, push;
    if (in_rs) begin
      q.delete();
    end else begin
      pop  = exp_valid && in_rr;
      push = in_wv && !exp_full;
      if (pop) q.delete(0);
      if (push) q.push_back('{d: in_wd, t: cyc});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    drive(0, '0, 0, 1); advance();
    drive(0, '0, 0, 1); advance();
    drive(0, '0, 0, 0);
    total++; if (level !== '0)     begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (empty !== 1'b1)   begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0)    begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
    advance();
  endtask

  task automatic test_latency();
    drive(1, 8'hA5, 0, 0); advance();
    for (int k = 0; k < 12; k++) begin
      drive(0, '0, 0, 0);
      total++;
      if (rd_valid !== (k >= 1)) begin
        bad++; $display("FAIL latency_valid k=%0d got=%b want=%b", k, rd_valid, (k >= 1));
      end
      total++;
      if (rd_valid !== exp_valid) begin
        bad++; $display("FAIL latency_model_valid k=%0d got=%b want=%b", k, rd_valid, exp_valid);
      end
      if (k >= 1) begin
        total++;
        if (rd_data !== 8'hA5) begin bad++; $display("FAIL latency_data k=%0d got=%h want=a5", k, rd_data); end
      end
      advance();
    end
    drive(0, '0, 1, 0); advance();
    drive(0, '0, 0, 0);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL latency_drain_empty got=%b want=1", empty); end
    advance();
  endtask

  task automatic test_fill();
    int n;
    for (int i = 0; i < 9; i++) begin
      drive(1, 8'(8'h10 + i), 0, 0);
      total++;
      if (wr_ready !== !exp_full) begin bad++; $display("FAIL fill_wr_ready i=%0d got=%b want=%b", i, wr_ready, !exp_full); end
      total++;
      if (level !== (AW+1)'(exp_level)) begin bad++; $display("FAIL fill_level i=%0d got=%0d want=%0d", i, level, exp_level); end
      advance();
    end
    drive(0, '0, 0, 0);
    total++; if (full !== 1'b1)     begin bad++; $display("FAIL fill_full got=%b want=1", full); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fill_wr_ready_full got=%b want=0", wr_ready); end
    total++; if (level !== 4'd8)    begin bad++; $display("FAIL fill_level_8 got=%0d want=8", level); end
    advance();
    n = 0;
    for (int c = 0; c < 20; c++) begin
      drive(0, '0, 1, 0);
      if (exp_valid) begin
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 8'(8'h10 + n)) begin
          bad++; $display("FAIL fill_drain n=%0d got=%b/%h want=1/%h", n, rd_valid, rd_data, 8'(8'h10 + n));
        end
        n++;
      end
      advance();
    end
    total++; if (n != 8) begin bad++; $display("FAIL fill_drain_count got=%0d want=8", n); end
    drive(0, '0, 0, 0);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_empty_after got=%b want=1", empty); end
    advance();
  endtask

  task automatic test_streaming();
    int n = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1, 8'(i), 1, 0);
      total++;
      if (level > 4'd2 || level !== (AW+1)'(exp_level)) begin
        bad++; $display("FAIL stream_level i=%0d got=%0d want=%0d", i, level, exp_level);
      end
      total++;
      if (rd_valid !== exp_valid) begin bad++; $display("FAIL stream_valid i=%0d got=%b want=%b", i, rd_valid, exp_valid); end
      if (exp_valid) begin
        total++;
        if (rd_data !== 8'(n)) begin bad++; $display("FAIL stream_data i=%0d got=%h want=%h", i, rd_data, 8'(n)); end
        n++;
      end
      advance();
    end
    total++; if (n != 98) begin bad++; $display("FAIL stream_count got=%0d want=98", n); end
    for (int c = 0; c < 6; c++) begin
      drive(0, '0, 1, 0);
      if (exp_valid) begin
        total++;
        if (rd_data !== 8'(n)) begin bad++; $display("FAIL stream_tail got=%h want=%h", rd_data, 8'(n)); end
        n++;
      end
      advance();
    end
    total++; if (n != 100) begin bad++; $display("FAIL stream_total got=%0d want=100", n); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0);
      total++;
      if (level !== (AW+1)'(exp_level)) begin bad++; $display("FAIL rand_level i=%0d got=%0d want=%0d", i, level, exp_level); end
      total++;
      if (rd_valid !== exp_valid) begin bad++; $display("FAIL rand_valid i=%0d got=%b want=%b", i, rd_valid, exp_valid); end
      total++;
      if (full !== exp_full || wr_ready !== !exp_full || empty !== (exp_level == 0)) begin
        bad++; $display("FAIL rand_flags i=%0d got=f%b r%b e%b lvl=%0d", i, full, wr_ready, empty, exp_level);
      end
      if (exp_valid) begin
        total++;
        if (rd_data !== exp_data) begin bad++; $display("FAIL rand_data i=%0d got=%h want=%h", i, rd_data, exp_data); end
      end
      advance();
    end
  endtask

  task automatic test_mid_rst();
    bit seen = 0;
    drive(0, '0, 0, 1); advance();
    for (int i = 0; i < 5; i++) begin drive(1, 8'($urandom), 0, 0); advance(); end
    drive(0, '0, 0, 0); advance();
    drive(0, '0, 0, 0);
    total++; if (level !== 4'd5) begin bad++; $display("FAIL midrst_pre_level got=%0d want=5", level); end
    advance();
    drive(0, '0, 0, 1); advance();
    drive(0, '0, 0, 0);
    total++; if (level !== '0)      begin bad++; $display("FAIL midrst_level got=%0d want=0", level); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_rd_valid got=%b want=0", rd_valid); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL midrst_wr_ready got=%b want=1", wr_ready); end
    advance();
    drive(1, 8'h3C, 0, 0); advance();
    for (int c = 0; c < 6 && !seen; c++) begin
      drive(0, '0, 1, 0);
      if (rd_valid === 1'b1) begin
        seen = 1;
        total++;
        if (rd_data !== 8'h3C) begin bad++; $display("FAIL midrst_data got=%h want=3c", rd_data); end
      end
      advance();
    end
    total++; if (!seen) begin bad++; $display("FAIL midrst_timeout got=no_rd_valid want=rd_valid"); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_streaming();
    test_random();
    test_mid_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
